vol_ramp_ctrl: RTL and testbench
================================

// Module: vol_ramp_ctrl
// PURPOSE
//  Owns the VS1003 SCI_VOL setting. Takes button up/down pulses and Bluetooth absolute-volume
//  commands, arbitrates them into one target level (0 = loudest .. 15 = quietest), and ramps
//  the applied level toward the target one step per SCI write.
//  Each write goes out as a 16-bit word {L,4'h0,L,4'h0} (0x0000..0xF0F0) to the SCI writer
//  over a req/ack handshake. vol_level drives the LED bar-graph decoder.
// PARAMETERS
//  HOLD_CYC     50000  clk cycles of settle time after each acked write before the next step (>=1)
//  RESET_LEVEL  4'd4   level loaded into current and target at reset
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  btn_up     in   1   1-cycle pulse (debounced upstream): target louder (level-1)
//  btn_dn     in   1   1-cycle pulse: target quieter (level+1)
//  bt_valid   in   1   1-cycle pulse: load bt_level as target
//  bt_level   in   4   absolute target level, sampled when bt_valid=1
//  vol_req    out  1   write request to SCI writer
//  vol_word   out  16  SCI_VOL data; stable while vol_req=1
//  vol_ack    in   1   SCI writer accepted vol_word (may assert in the same cycle as vol_req)
//  vol_level  out  4   last acked level
//  busy       out  1   1 when state != IDLE or current != target
// BEHAVIOUR
//  Reset: vol_req=0, vol_word={RESET_LEVEL,0,RESET_LEVEL,0}, vol_level=RESET_LEVEL,
//   target=RESET_LEVEL, state=INIT.
//  FSM states: INIT, IDLE, REQ, HOLD.
//   INIT: next cycle goes to REQ with level=RESET_LEVEL, so the decoder is programmed once after reset.
//   IDLE: if target!=current, step=current-1 (target<current) or current+1 (target>current);
//    load vol_word from step; go to REQ. Otherwise stay in IDLE.
//   REQ: vol_req=1 and vol_word is frozen. On vol_ack=1 (sampled at the clk edge): vol_req=0 next
//    cycle, vol_level=step, hold counter=HOLD_CYC-1, go to HOLD.
//   HOLD: decrement counter every cycle; at 0 go to IDLE. Total gap from ack to next req is
//    >= HOLD_CYC+1 cycles.
//  Target update runs in every state (the step in flight is not affected).
//   Priority when events coincide: bt_valid > btn_up > btn_dn.
//   btn_up saturates at 0 and btn_dn saturates at 15; there is no wrap-around.
//   A button adjusts the current target, not vol_level. Repeated presses during a ramp accumulate.
//  Word format: vol_word = {L,4'h0,L,4'h0}. Both channels are always equal.
//  Reset asserted mid-handshake: vol_req drops asynchronously and the pending step is discarded.
//  Latency: from an idle, settled state, a target change gives vol_req=1 two cycles after the pulse.
// CONFIGURATION
//  VOL_MUTE_EN defined:
//   - Adds input port mute_tgl (1-cycle pulse) and an internal mute flag (reset 0).
//   - The toggle is sampled in any state.
//   - When the flag differs from the applied mute state, IDLE issues a write before any ramp step:
//     - muting writes 16'hFEFE (VS1003 analog powerdown/silence);
//     - unmuting rewrites the current level word.
//   - While muted, ramp steps still run internally, but vol_word stays 16'hFEFE and vol_level tracks
//     the steps.
//  VOL_MUTE_EN undefined: no mute_tgl port, no mute logic; vol_word is always a level word.
// TESTING
//  1 Reset release, ack tied 1 -> one req with word 0x4040; vol_level=4; then busy=0.
//  2 Idle at 4, bt_valid with bt_level=7, ack 1 cycle after req, HOLD_CYC=8 -> words 0x5050,
//    0x6060, 0x7070 in order, gap >=9 cycles between ack and next req.
//  3 At level 0, three btn_up pulses -> no req, target stays 0.
//    At level 15, btn_dn -> no req.
//  4 Same cycle bt_valid(bt_level=2) + btn_dn at level 4 -> target 2; words 0x3030, 0x2020 only.
//  5 Ack withheld 20 cycles -> vol_word stable, vol_req=1 throughout; btn_dn during the wait is
//    applied after the current step.
//  6 Reset pulsed while vol_req=1 -> vol_req=0 immediately; after release, the next word is
//    0x4040 (RESET_LEVEL).
//  7 (VOL_MUTE_EN) At level 3, mute_tgl -> word 0xFEFE.
//    Second mute_tgl -> word 0x3030.

Source files
------------

// File: rtl/vol_ramp_ctrl.sv
// VS1003 SCI_VOL owner: arbitrates button/Bluetooth volume into a target and ramps one step per write.
// Optional mute support is compiled in when VOL_MUTE_EN is defined.
module vol_ramp_ctrl #(
    parameter int unsigned HOLD_CYC    = 50000,
    parameter logic [3:0]  RESET_LEVEL = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic        bt_valid,
    input  logic [3:0]  bt_level,
`ifdef VOL_MUTE_EN
    input  logic        mute_tgl,
`endif
    output logic        vol_req,
    output logic [15:0] vol_word,
    input  logic        vol_ack,
    output logic [3:0]  vol_level,
    output logic        busy
);

    localparam int              CNT_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [15:0]     MUTE_WORD = 16'hFEFE;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    function automatic logic [15:0] lvl_word(input logic [3:0] l);
        return {l, 4'h0, l, 4'h0};
    endfunction

    state_t           state_q;
    logic [3:0]       tgt_q, tgt_d;
    logic [3:0]       cur_q;
    logic [3:0]       step_q;
    logic [3:0]       step_nx;
    logic [15:0]      word_q;
    logic [15:0]      step_word;
    logic             req_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef VOL_MUTE_EN
    logic             mute_q;
    logic             mute_app_q;
    logic             mute_wr_q;
`endif

    // Target arbitration: Bluetooth absolute level beats buttons; buttons saturate at 0/15.
    always_comb begin
        tgt_d = tgt_q;
        if (bt_valid) begin
            tgt_d = bt_level;
        end else if (btn_up) begin
            if (tgt_q != 4'd0) tgt_d = tgt_q - 4'd1;
        end else if (btn_dn) begin
            if (tgt_q != 4'd15) tgt_d = tgt_q + 4'd1;
        end
    end

    always_comb begin
        step_nx   = (tgt_q < cur_q) ? cur_q - 4'd1 : cur_q + 4'd1;
        step_word = lvl_word(step_nx);
`ifdef VOL_MUTE_EN
        if (mute_app_q) step_word = MUTE_WORD;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            tgt_q      <= RESET_LEVEL;
            cur_q      <= RESET_LEVEL;
            step_q     <= RESET_LEVEL;
            word_q     <= lvl_word(RESET_LEVEL);
            req_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef VOL_MUTE_EN
            mute_q     <= 1'b0;
            mute_app_q <= 1'b0;
            mute_wr_q  <= 1'b0;
`endif
        end else begin
            tgt_q <= tgt_d;
`ifdef VOL_MUTE_EN
            if (mute_tgl) mute_q <= ~mute_q;
`endif
            case (state_q)
                ST_INIT: begin
                    step_q  <= RESET_LEVEL;
                    word_q  <= lvl_word(RESET_LEVEL);
                    req_q   <= 1'b1;
                    state_q <= ST_REQ;
                end
                ST_IDLE: begin
`ifdef VOL_MUTE_EN
                    // A pending mute change is written before any ramp step.
                    if (mute_q != mute_app_q) begin
                        step_q    <= cur_q;
                        word_q    <= mute_q ? MUTE_WORD : lvl_word(cur_q);
                        mute_wr_q <= mute_q;
                        req_q     <= 1'b1;
                        state_q   <= ST_REQ;
                    end else
`endif
                    if (tgt_q != cur_q) begin
                        step_q  <= step_nx;
                        word_q  <= step_word;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
`ifdef VOL_MUTE_EN
                        mute_wr_q <= mute_app_q;
`endif
                    end
                end
                ST_REQ: begin
                    if (vol_ack) begin
                        req_q   <= 1'b0;
                        cur_q   <= step_q;
                        cnt_q   <= HOLD_LOAD;
                        state_q <= ST_HOLD;
`ifdef VOL_MUTE_EN
                        mute_app_q <= mute_wr_q;
`endif
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vol_req   = req_q;
    assign vol_word  = word_q;
    assign vol_level = cur_q;
    assign busy      = (state_q != ST_IDLE) || (cur_q != tgt_q);

endmodule

// File: tb/tb_vol_ramp_ctrl.sv
// Bench for vol_ramp_ctrl: directed scenarios plus randomized target traffic checked against
// a target model and ramp-shape rules (unit steps, level words, settle gap, final level).
module tb_vol_ramp_ctrl;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic        bt_valid = 1'b0;
    logic [3:0]  bt_level = 4'd0;
    logic        vol_ack = 1'b0;
    logic        vol_req;
    logic [15:0] vol_word;
    logic [3:0]  vol_level;
    logic        busy;
`ifdef VOL_MUTE_EN
    logic        mute_tgl = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int ack_dly = 0;
    bit ack_tied = 1'b0;
    int cyc = 0;
    int evt_cyc = 0;
    logic req_prev = 1'b0;
    logic [15:0] wq[$];
    int ackc[$];
    int reqc[$];
    int mtgt = 4;

    always #5 clk = ~clk;

    vol_ramp_ctrl #(.HOLD_CYC(HOLD), .RESET_LEVEL(4'd4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .bt_valid (bt_valid),
        .bt_level (bt_level),
`ifdef VOL_MUTE_EN
        .mute_tgl (mute_tgl),
`endif
        .vol_req  (vol_req),
        .vol_word (vol_word),
        .vol_ack  (vol_ack),
        .vol_level(vol_level),
        .busy     (busy)
    );

    // Monitor: values seen here are the ones the DUT samples at this edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (vol_req && !req_prev) reqc.push_back(cyc);
            if (vol_req && vol_ack) begin
                wq.push_back(vol_word);
                ackc.push_back(cyc);
            end
            if (bt_valid || btn_up || btn_dn) evt_cyc <= cyc;
        end
        req_prev <= vol_req;
        cyc <= cyc + 1;
    end

    // SCI writer model: either ack tied high or ack after ack_dly cycles of request.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (ack_tied) begin
                vol_ack = 1'b1;
                wcnt = 0;
            end else if (vol_req && !vol_ack) begin
                if (wcnt >= ack_dly) vol_ack = 1'b1;
                else wcnt++;
            end else begin
                vol_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    function automatic int model_next(int t, bit bv, int lvl, bit up, bit dn);
        if (bv) return lvl;
        if (up) return (t == 0) ? 0 : t - 1;
        if (dn) return (t == 15) ? 15 : t + 1;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clrq();
        wq.delete();
        ackc.delete();
        reqc.delete();
    endtask

    task automatic pulse(input bit up, input bit dn, input bit bv, input int lvl);
        btn_up = up;
        btn_dn = dn;
        bt_valid = bv;
        bt_level = 4'(lvl);
        mtgt = model_next(mtgt, bv, lvl, up, dn);
        @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        bt_valid = 1'b0;
    endtask

    task automatic wait_settle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " settle"}, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_words(input string tag, input int cnt);
        int n;
        n = 0;
        while (wq.size() < cnt && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " words seen"}, 32'(wq.size() >= cnt), 32'd1);
    endtask

    function automatic logic [15:0] wq_at(input int i);
        return (i < wq.size()) ? wq[i] : 16'hxxxx;
    endfunction

    task automatic check_ramp(input string tag, input int start);
        int prev;
        int d;
        prev = start;
        for (int i = 0; i < wq.size(); i++) begin
            logic [3:0] l;
            l = wq[i][15:12];
            chk({tag, " word fmt"}, wq[i], {l, 4'h0, l, 4'h0});
            d = (int'(l) > prev) ? int'(l) - prev : prev - int'(l);
            chk({tag, " unit step"}, d, 1);
            prev = int'(l);
        end
        for (int i = 0; i + 1 < reqc.size() && i < ackc.size(); i++)
            chk({tag, " hold gap"}, 32'((reqc[i+1] - ackc[i]) >= HOLD + 1), 32'd1);
        chk({tag, " final level"}, vol_level, mtgt);
    endtask

    initial begin
        logic [15:0] w0;
        bit stable;
        int n;
        int start;

        // Reset state
        ack_tied = 1'b1;
        tick(3);
        chk("rst vol_req", vol_req, 0);
        chk("rst vol_word", vol_word, 16'h4040);
        chk("rst vol_level", vol_level, 4);
        chk("rst busy", busy, 1);
        clrq();
        rst_n = 1'b1;

        // Power-up programming with ack tied high
        wait_words("t1", 1);
        tick(HOLD + 5);
        chk("t1 write count", wq.size(), 1);
        chk("t1 word", wq_at(0), 16'h4040);
        chk("t1 level", vol_level, 4);
        chk("t1 busy", busy, 0);

        // Bluetooth ramp 4 -> 7, ack one cycle after request
        ack_tied = 1'b0;
        ack_dly = 1;
        clrq();
        pulse(0, 0, 1, 7);
        wait_settle("t2");
        chk("t2 write count", wq.size(), 3);
        chk("t2 word0", wq_at(0), 16'h5050);
        chk("t2 word1", wq_at(1), 16'h6060);
        chk("t2 word2", wq_at(2), 16'h7070);
        chk("t2 latency", (reqc.size() > 0) ? reqc[0] - evt_cyc : -1, 2);
        check_ramp("t2", 4);

        // Saturation at both ends
        pulse(0, 0, 1, 0);
        wait_settle("t3a");
        clrq();
        repeat (3) pulse(1, 0, 0, 0);
        tick(20);
        chk("t3 up writes", wq.size(), 0);
        chk("t3 up level", vol_level, 0);
        chk("t3 up busy", busy, 0);
        pulse(0, 0, 1, 15);
        wait_settle("t3b");
        clrq();
        pulse(0, 1, 0, 0);
        tick(20);
        chk("t3 dn writes", wq.size(), 0);
        chk("t3 dn level", vol_level, 15);
        chk("t3 dn busy", busy, 0);

        // Coincident bt_valid and btn_dn
        pulse(0, 0, 1, 4);
        wait_settle("t4a");
        clrq();
        pulse(0, 1, 1, 2);
        wait_settle("t4");
        chk("t4 write count", wq.size(), 2);
        chk("t4 word0", wq_at(0), 16'h3030);
        chk("t4 word1", wq_at(1), 16'h2020);

        // Ack withheld; button during the wait lands after the current step
        ack_dly = 20;
        clrq();
        pulse(0, 1, 0, 0);
        n = 0;
        while (vol_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5 req seen", vol_req, 1);
        w0 = vol_word;
        stable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 5) begin
                btn_dn = 1'b1;
                mtgt = model_next(mtgt, 0, 0, 0, 1);
            end else begin
                btn_dn = 1'b0;
            end
            @(negedge clk);
            if (vol_req !== 1'b1 || vol_word !== w0) stable = 1'b0;
        end
        btn_dn = 1'b0;
        chk("t5 word held", w0, 16'h3030);
        chk("t5 stable", stable, 1);
        wait_settle("t5");
        chk("t5 write count", wq.size(), 2);
        chk("t5 word1", wq_at(1), 16'h4040);
        chk("t5 level", vol_level, 4);

        // Reset during a pending request
        ack_dly = 1000;
        pulse(0, 0, 1, 9);
        n = 0;
        while (vol_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6 req seen", vol_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async req drop", vol_req, 0);
        chk("t6 async word", vol_word, 16'h4040);
        clrq();
        mtgt = 4;
        ack_dly = 1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_settle("t6");
        chk("t6 write count", wq.size(), 1);
        chk("t6 word", wq_at(0), 16'h4040);
        chk("t6 level", vol_level, 4);

`ifdef VOL_MUTE_EN
        // Mute toggles
        pulse(0, 0, 1, 3);
        wait_settle("t7a");
        clrq();
        mute_tgl = 1'b1;
        @(negedge clk);
        mute_tgl = 1'b0;
        wait_words("t7 mute", 1);
        chk("t7 mute word", wq_at(0), 16'hFEFE);
        chk("t7 mute level", vol_level, 3);
        tick(HOLD + 4);
        mute_tgl = 1'b1;
        @(negedge clk);
        mute_tgl = 1'b0;
        wait_words("t7 unmute", 2);
        chk("t7 unmute word", wq_at(1), 16'h3030);
        wait_settle("t7");
`endif

        // Randomized target traffic
        for (int ph = 0; ph < 12; ph++) begin
            ack_tied = ($urandom_range(0, 3) == 0);
            ack_dly = $urandom_range(0, 3);
            clrq();
            start = int'(vol_level);
            for (int k = 0; k < 30; k++) begin
                int r;
                int lvl;
                r = $urandom_range(0, 7);
                lvl = $urandom_range(0, 15);
                case (r)
                    0: pulse(0, 0, 1, lvl);
                    1: pulse(1, 0, 0, 0);
                    2: pulse(0, 1, 0, 0);
                    3: pulse(1, 1, 0, 0);
                    4: pulse(1, 0, 1, lvl);
                    default: @(negedge clk);
                endcase
            end
            wait_settle("rnd");
            check_ramp("rnd", start);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
